e203_ifu_predec_fifo: RTL and testbench

- Parametrised, buffered successor to the IFU mini-decoder. It sits between the IFU fetch response and the IR/EXU hand-off.
- Each fetched instruction is mini-decoded at push time: rv32, branch/jump class, jalr rs1 index, immediate, and a static prediction with target PC.
- The decoded instruction and its PC are held in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- A synchronous flush drops all entries on redirect.

---
 rtl/e203_ifu_predec_fifo.sv | 143 ++++++++++++++
 tb/tb_e203_ifu_predec_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_ifu_predec_fifo.sv
// rtl/e203_ifu_predec_fifo.sv - IFU mini-decoder with static prediction feeding a DEPTH-entry FIFO
module e203_ifu_predec_fifo #(
    parameter int DEPTH   = 2,
    parameter int PC_W    = 32,
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int CNT_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [31:0]         i_instr,
    input  logic [PC_W-1:0]     i_pc,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [31:0]         o_instr,
    output logic [PC_W-1:0]     o_pc,
    output logic                o_rv32,
    output logic                o_bjp,
    output logic                o_jal,
    output logic                o_jalr,
    output logic                o_bxx,
    output logic [RFIDX_W-1:0]  o_jalr_rs1idx,
    output logic [XLEN-1:0]     o_bjp_imm,
    output logic                o_prdt_taken,
    output logic [PC_W-1:0]     o_prdt_pc,
    output logic [CNT_W-1:0]    o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0]        instr;
        logic [PC_W-1:0]    pc;
        logic               rv32;
        logic               jal;
        logic               jalr;
        logic               bxx;
        logic [RFIDX_W-1:0] rs1idx;
        logic [XLEN-1:0]    imm;
        logic               taken;
        logic [PC_W-1:0]    prdt_pc;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             dec;
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [6:0]         opcode;
    logic [2:0]         funct3;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];

    // Push-side decode; everything beyond rv32 is gated so 16-bit parcels carry no prediction.
    always_comb begin
        dec        = '0;
        dec.instr  = i_instr;
        dec.pc     = i_pc;
        dec.rv32   = (i_instr[1:0] == 2'b11);
        dec.jal    = dec.rv32 & (opcode == 7'b1101111);
        dec.jalr   = dec.rv32 & (opcode == 7'b1100111) & (funct3 == 3'b000);
        dec.bxx    = dec.rv32 & (opcode == 7'b1100011) &
                     (funct3 != 3'b010) & (funct3 != 3'b011);
        if (dec.jal) begin
            dec.imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};
        end else if (dec.jalr) begin
            dec.imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
        end else if (dec.bxx) begin
            dec.imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};
        end
        if (dec.jalr) begin
            dec.rs1idx = RFIDX_W'(i_instr[19:15]);
        end
        dec.taken = dec.jal | dec.jalr | (dec.bxx & dec.imm[XLEN-1]);
        // jalr target depends on rs1, so only pc-relative forms get a predicted PC.
        if (dec.jal | dec.bxx) begin
            dec.prdt_pc = i_pc + dec.imm;
        end
    end

    assign o_valid = (count != '0) & ~rst;
    assign i_ready = (count < FULL_CNT) & ~rst & ~flush;
    assign push    = i_valid & i_ready;
    assign pop     = o_valid & o_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Unread storage is never reset, so the head is masked to zero whenever it is not valid.
    always_comb begin
        head = '0;
        if (o_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign o_instr       = head.instr;
    assign o_pc          = head.pc;
    assign o_rv32        = head.rv32;
    assign o_jal         = head.jal;
    assign o_jalr        = head.jalr;
    assign o_bxx         = head.bxx;
    assign o_bjp         = head.jal | head.jalr | head.bxx;
    assign o_jalr_rs1idx = head.rs1idx;
    assign o_bjp_imm     = head.imm;
    assign o_prdt_taken  = head.taken;
    assign o_prdt_pc     = head.prdt_pc;
    assign o_count       = count;

endmodule

// File: tb/tb_e203_ifu_predec_fifo.sv
// tb/tb_e203_ifu_predec_fifo.sv - self-checking bench for e203_ifu_predec_fifo
module tb_e203_ifu_predec_fifo;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [31:0] i_instr = '0;
    logic [31:0] i_pc = '0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_rv32, o_bjp, o_jal, o_jalr, o_bxx;
    logic [4:0]  o_jalr_rs1idx;
    logic [31:0] o_bjp_imm;
    logic        o_prdt_taken;
    logic [31:0] o_prdt_pc;
    logic [1:0]  o_count;

    e203_ifu_predec_fifo #(.DEPTH(DEPTH), .PC_W(32), .XLEN(32), .RFIDX_W(5), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr), .i_pc(i_pc),
        .o_valid(o_valid), .o_ready(o_ready), .o_instr(o_instr), .o_pc(o_pc),
        .o_rv32(o_rv32), .o_bjp(o_bjp), .o_jal(o_jal), .o_jalr(o_jalr), .o_bxx(o_bxx),
        .o_jalr_rs1idx(o_jalr_rs1idx), .o_bjp_imm(o_bjp_imm),
        .o_prdt_taken(o_prdt_taken), .o_prdt_pc(o_prdt_pc), .o_count(o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [31:0] instr;
        bit [31:0] pc;
        bit        rv32, jal, jalr, bxx;
        bit [4:0]  rs1;
        bit [31:0] imm;
        bit        taken;
        bit [31:0] ppc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   checking = 1'b0;
    bit   m_valid, m_ready, m_push, m_pop;
    exp_t h;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference decode straight from the ISA field layouts.
    function automatic exp_t model(bit [31:0] ins, bit [31:0] pc);
        exp_t m;
        logic signed [31:0] s;
        m = '{default: 0};
        m.instr = ins;
        m.pc    = pc;
        m.rv32  = (ins[1:0] == 2'd3);
        s = 0;
        if (m.rv32) begin
            case (ins[6:0])
                7'h6F: m.jal  = 1;
                7'h67: m.jalr = (ins[14:12] == 3'd0);
                7'h63: m.bxx  = !(ins[14:12] inside {3'd2, 3'd3});
                default: ;
            endcase
        end
        if (m.jal)       s = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        else if (m.jalr) s = $signed(ins[31:20]);
        else if (m.bxx)  s = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        m.imm   = s;
        m.rs1   = m.jalr ? ins[19:15] : 5'd0;
        m.taken = m.jal || m.jalr || (m.bxx && s < 0);
        m.ppc   = (m.jal || m.bxx) ? pc + m.imm : 32'd0;
        return m;
    endfunction

    always @(posedge clk) begin
        m_valid = (q.size() != 0) && !rst;
        m_ready = (q.size() < DEPTH) && !rst && !flush;
        m_push  = i_valid && m_ready;
        m_pop   = m_valid && o_ready;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(model(i_instr, i_pc));
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            m_valid = (q.size() != 0) && !rst;
            m_ready = (q.size() < DEPTH) && !rst && !flush;
            h = m_valid ? q[0] : '{default: 0};
            chk("o_valid", o_valid, m_valid);
            chk("i_ready", i_ready, m_ready);
            chk("o_count", o_count, q.size());
            chk("o_instr", o_instr, h.instr);
            chk("o_pc", o_pc, h.pc);
            chk("o_rv32", o_rv32, h.rv32);
            chk("o_jal", o_jal, h.jal);
            chk("o_jalr", o_jalr, h.jalr);
            chk("o_bxx", o_bxx, h.bxx);
            chk("o_bjp", o_bjp, h.jal | h.jalr | h.bxx);
            chk("o_jalr_rs1idx", o_jalr_rs1idx, h.rs1);
            chk("o_bjp_imm", o_bjp_imm, h.imm);
            chk("o_prdt_taken", o_prdt_taken, h.taken);
            chk("o_prdt_pc", o_prdt_pc, h.ppc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, bit [31:0] ins, bit [31:0] pc, bit rdy, bit fl);
        i_valid = v;
        i_instr = ins;
        i_pc    = pc;
        o_ready = rdy;
        flush   = fl;
    endtask

    function automatic bit [31:0] rand_instr();
        bit [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: r[6:0] = 7'h6F;
            1: begin r[6:0] = 7'h67; if ($urandom_range(0, 1) == 1) r[14:12] = 3'd0; end
            2, 3: r[6:0] = 7'h63;
            4: if (r[1:0] == 2'd3) r[1:0] = 2'd1;
            default: ;
        endcase
        return r;
    endfunction

    bit [31:0] prev_pc;

    initial begin
        step();
        checking = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("reset_count", o_count, 0);
        chk("reset_valid", o_valid, 0);
        chk("reset_ready", i_ready, 1);

        drive(1, 32'h0100006F, 32'h80000000, 0, 0);
        step();
        chk("jal_valid", o_valid, 1);
        chk("jal_flag", {o_jal, o_bjp}, 2'b11);
        chk("jal_imm", o_bjp_imm, 32'h10);
        chk("jal_taken", o_prdt_taken, 1);
        chk("jal_ppc", o_prdt_pc, 32'h80000010);
        chk("jal_count", o_count, 1);

        drive(1, 32'hFE000EE3, 32'h80000100, 1, 0);
        step();
        chk("beqb_bxx", o_bxx, 1);
        chk("beqb_imm", o_bjp_imm, 32'hFFFFFFFC);
        chk("beqb_taken", o_prdt_taken, 1);
        chk("beqb_ppc", o_prdt_pc, 32'h800000FC);

        drive(1, 32'h00000863, 32'h80000200, 1, 0);
        step();
        chk("beqf_taken", o_prdt_taken, 0);
        chk("beqf_ppc", o_prdt_pc, 32'h80000210);

        drive(1, 32'h008280E7, 32'h80000300, 1, 0);
        step();
        chk("jalr_flag", o_jalr, 1);
        chk("jalr_rs1", o_jalr_rs1idx, 5);
        chk("jalr_imm", o_bjp_imm, 8);
        chk("jalr_taken", o_prdt_taken, 1);
        chk("jalr_ppc", o_prdt_pc, 0);

        drive(1, 32'h00000001, 32'h80000400, 1, 0);
        step();
        chk("c16_rv32", o_rv32, 0);
        chk("c16_bjp", o_bjp, 0);
        chk("c16_imm", o_bjp_imm, 0);
        drive(0, 0, 0, 1, 0);
        step();
        chk("drain_valid", o_valid, 0);

        // Fill to full with the consumer stalled, then release it.
        drive(1, 32'h00000013, 32'h0000A000, 0, 0);
        step();
        drive(1, 32'h00000013, 32'h0000B000, 0, 0);
        step();
        chk("full_count", o_count, 2);
        chk("full_ready", i_ready, 0);
        drive(1, 32'h00000013, 32'h0000C000, 0, 0);
        step();
        chk("full_head", o_pc, 32'h0000A000);
        drive(1, 32'h00000013, 32'h0000C000, 1, 0);
        step();
        chk("full_pop_count", o_count, 1);
        chk("full_pop_head", o_pc, 32'h0000B000);
        step();
        chk("wrap_head", o_pc, 32'h0000C000);
        chk("wrap_count", o_count, 1);
        drive(0, 0, 0, 1, 0);
        step();

        drive(1, 32'h00000013, 32'h0000D000, 0, 0);
        step();
        drive(1, 32'h00000013, 32'h0000E000, 1, 1);
        step();
        chk("flush_count", o_count, 0);
        chk("flush_valid", o_valid, 0);
        drive(0, 0, 0, 1, 0);
        step();
        chk("flush_after", o_valid, 0);

        drive(1, 32'h00000013, 32'h00010000, 0, 0);
        step();
        prev_pc = 32'h00010000;
        for (int k = 0; k < 8; k++) begin
            drive(1, 32'h00000013, 32'h00010004 + 32'(k) * 4, 1, 0);
            step();
            chk("stream_count", o_count, 1);
            chk("stream_pc", o_pc, prev_pc + 4);
            prev_pc = prev_pc + 4;
        end

        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
